wb_port_arbiter: RTL

Arbiter and scoreboard for the single register-file write port of the rv32i core. Shares the port between the in-order writeback stage (fixed priority, never stalled by this block) and a long-latency unit (LU, e.g. mul/div) that returns results out of band. Holds LU results in a small FIFO while the pipeline owns the port. Tracks in-flight LU destinations so the hazard unit can stall dependent or conflicting instructions.

---
 rtl/wb_port_arbiter.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/wb_port_arbiter.sv
`timescale 1ns/1ps
// Register-file write-port arbiter: writeback always wins, LU results wait in a small FIFO,
// and a scoreboard tracks outstanding LU destinations. Define WBARB_BYPASS_EN for same-cycle LU bypass.
module wb_port_arbiter #(
    parameter int DPW          = 32,
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           regwriteW,
    input  logic [4:0]     RdW,
    input  logic [DPW-1:0] resultW,
    input  logic           lu_valid,
    input  logic [4:0]     lu_rd,
    input  logic [DPW-1:0] lu_data,
    output logic           lu_ready,
    input  logic           issue_valid,
    input  logic [4:0]     issue_rd,
    input  logic [4:0]     rs1D,
    input  logic [4:0]     rs2D,
    output logic           stallD,
    output logic           hold_req,
    output logic           rf_we,
    output logic [4:0]     rf_waddr,
    output logic [DPW-1:0] rf_wdata,
    output logic [31:0]    pending
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int STV_W = $clog2(STARVE_LIMIT + 1);

    logic [4:0]       rd_mem_q  [DEPTH];
    logic [DPW-1:0]   dat_mem_q [DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [STV_W-1:0] starve_q, starve_d;
    logic             hold_q, hold_d;
    logic [31:0]      pending_q, pending_d;

    logic        pw, fifo_empty, accept, bypass, pop, push, lu_grant;
    logic [31:0] clr_vec, set_vec;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) return '0;
        return p + PTR_W'(1);
    endfunction

    assign pw         = regwriteW && (RdW != 5'd0);
    assign fifo_empty = (count_q == '0);
    // lu_ready looks only at the registered count so it never depends on this cycle's grant
    assign lu_ready   = (count_q < CNT_W'(DEPTH));
    assign accept     = lu_valid && lu_ready;
`ifdef WBARB_BYPASS_EN
    assign bypass     = accept && fifo_empty && !pw;
`else
    assign bypass     = 1'b0;
`endif
    assign pop        = !pw && !fifo_empty;
    // x0 results are swallowed at accept and never occupy a FIFO slot
    assign push       = accept && (lu_rd != 5'd0) && !bypass;

    always_comb begin
        rf_we    = 1'b0;
        rf_waddr = 5'd0;
        rf_wdata = '0;
        lu_grant = 1'b0;
        if (pw) begin
            rf_we    = 1'b1;
            rf_waddr = RdW;
            rf_wdata = resultW;
        end else if (pop) begin
            rf_we    = 1'b1;
            rf_waddr = rd_mem_q[head_q];
            rf_wdata = dat_mem_q[head_q];
            lu_grant = 1'b1;
        end else if (bypass && (lu_rd != 5'd0)) begin
            rf_we    = 1'b1;
            rf_waddr = lu_rd;
            rf_wdata = lu_data;
            lu_grant = 1'b1;
        end
    end

    assign clr_vec   = lu_grant ? (32'd1 << rf_waddr) : 32'd0;
    assign set_vec   = (issue_valid && (issue_rd != 5'd0)) ? (32'd1 << issue_rd) : 32'd0;
    // a new issue to the register being retired this cycle must stay pending
    assign pending_d = (pending_q & ~clr_vec) | set_vec;

    assign pending  = pending_q;
    assign hold_req = hold_q;
    assign stallD   = pending_q[rs1D] | pending_q[rs2D] | (issue_valid & pending_q[issue_rd]);

    always_comb begin
        head_d  = pop  ? next_ptr(head_q) : head_q;
        tail_d  = push ? next_ptr(tail_q) : tail_q;
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // A non-empty FIFO that is not popped means the pipeline took the port this cycle
    always_comb begin
        starve_d = starve_q;
        if (pop || fifo_empty)
            starve_d = '0;
        else if (starve_q != STV_W'(STARVE_LIMIT))
            starve_d = starve_q + STV_W'(1);
        hold_d = pop ? 1'b0 : (hold_q | (starve_q == STV_W'(STARVE_LIMIT)));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            starve_q  <= '0;
            hold_q    <= 1'b0;
            pending_q <= '0;
        end else begin
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            starve_q  <= starve_d;
            hold_q    <= hold_d;
            pending_q <= pending_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            rd_mem_q[tail_q]  <= lu_rd;
            dat_mem_q[tail_q] <= lu_data;
        end
    end

endmodule
